cic_decim_mc: RTL and testbench



---
 rtl/cic_pkg.sv | 17 +
 rtl/cic_lane.sv | 79 +++++++
 rtl/cic_decim_mc.sv | 69 ++++++
 tb/tb_cic_decim_mc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared width and shift helpers for the multi-channel CIC decimator.
// Output rounding is selected by the CIC_OUT_ROUND_EN macro in cic_lane.
package cic_pkg;

  function automatic int acc_width(input int in_w, input int stages, input int rate);
    return in_w + stages * $clog2(rate);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int shift_amt(input int acc_w, input int out_w);
    return acc_w - out_w;
  endfunction

endpackage

// File: rtl/cic_lane.sv
// Single-channel CIC datapath: integrator chain, comb chain, output scaling.
// CIC_OUT_ROUND_EN selects round-half-up scaling; default is truncation toward -inf.
module cic_lane
  import cic_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int STAGES = 3,
  parameter int RATE   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     in_data,
  input  logic                dec_en,
  input  logic [STAGES-1:0]   comb_en,
  input  logic                out_en,
  output logic [OUT_W-1:0]    out_data
);

  localparam int ACC_W = acc_width(IN_W, STAGES, RATE);
  localparam int SH    = shift_amt(ACC_W, OUT_W);

  logic signed [ACC_W-1:0] integ   [STAGES];
  logic signed [ACC_W-1:0] comb    [STAGES];
  logic signed [ACC_W-1:0] dly     [STAGES];
  logic signed [ACC_W-1:0] comb_in [STAGES];
  logic signed [ACC_W-1:0] dec_reg;
  logic signed [ACC_W-1:0] in_ext;
  logic        [OUT_W-1:0] scaled;

  always_comb begin
    in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    comb_in[0] = dec_reg;
    for (int unsigned k = 1; k < STAGES; k++) comb_in[k] = comb[k-1];
  end

`ifdef CIC_OUT_ROUND_EN
  if (SH > 0) begin : g_round
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SH - 1);
    logic signed [ACC_W:0] rsum;
    always_comb begin
      rsum   = $signed({comb[STAGES-1][ACC_W-1], comb[STAGES-1]}) + HALF;
      scaled = OUT_W'(rsum >>> SH);
    end
  end else begin : g_pass
    always_comb scaled = comb[STAGES-1][OUT_W-1:0];
  end
`else
  always_comb scaled = OUT_W'(comb[STAGES-1] >>> SH);
`endif

  // Integrators use pre-update values of the previous stage; wrap-around is intended.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ[k] <= '0;
        comb[k]  <= '0;
        dly[k]   <= '0;
      end
      dec_reg  <= '0;
      out_data <= '0;
    end else begin
      if (in_valid) begin
        integ[0] <= integ[0] + in_ext;
        for (int unsigned k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
      end
      if (dec_en) dec_reg <= integ[STAGES-1];
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (comb_en[k]) begin
          comb[k] <= comb_in[k] - dly[k];
          dly[k]  <= comb_in[k];
        end
      end
      if (out_en) out_data <= scaled;
    end
  end

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: shared phase counter, decimation strobe and comb valid pipe.
// Optional round-half-up output scaling via CIC_OUT_ROUND_EN.
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int STAGES   = 3,
  parameter int RATE     = 8,
  parameter int CHANNELS = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [CHANNELS*IN_W-1:0]    in_data,
  input  logic                        in_valid,
  output logic [CHANNELS*OUT_W-1:0]   out_data,
  output logic                        out_valid,
  output logic [$clog2(RATE)-1:0]     phase
);

  localparam int PW = $clog2(RATE);

  if (!is_pow2(RATE) || RATE < 2) begin : g_bad_rate
    $fatal(1, "cic_decim_mc: RATE must be a power of 2 and >= 2");
  end
  if (STAGES < 1 || CHANNELS < 1) begin : g_bad_size
    $fatal(1, "cic_decim_mc: STAGES and CHANNELS must be >= 1");
  end
  if (OUT_W > acc_width(IN_W, STAGES, RATE)) begin : g_bad_outw
    $fatal(1, "cic_decim_mc: OUT_W must not exceed the accumulator width");
  end

  logic              strobe;
  logic [STAGES:0]   vld;

  assign strobe = in_valid && (phase == PW'(RATE - 1));

  // vld[k] enables comb k; vld[STAGES] loads the output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase     <= '0;
      vld       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) phase <= phase + PW'(1);
      vld       <= {vld[STAGES-1:0], strobe};
      out_valid <= vld[STAGES];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    cic_lane #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .STAGES (STAGES),
      .RATE   (RATE)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_data  (in_data[c*IN_W +: IN_W]),
      .dec_en   (strobe),
      .comb_en  (vld[STAGES-1:0]),
      .out_en   (vld[STAGES]),
      .out_data (out_data[c*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Self-checking bench for cic_decim_mc: DC/sign/gap/wrap vector table, phase, mid-op reset, rounding.
// Rounding expectations follow CIC_OUT_ROUND_EN.
module tb_cic_decim_mc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic [2:0]  phase;

  logic [31:0] r_in;
  logic        r_valid;
  logic [29:0] r_out;
  logic        r_ovalid;
  logic [2:0]  r_phase;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cic_decim_mc #(.IN_W(16), .OUT_W(16), .STAGES(3), .RATE(8), .CHANNELS(2)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .phase(phase)
  );

  cic_decim_mc #(.IN_W(16), .OUT_W(15), .STAGES(3), .RATE(8), .CHANNELS(2)) dut_r (
    .clk(clk), .rstn(rstn), .in_data(r_in), .in_valid(r_valid),
    .out_data(r_out), .out_valid(r_ovalid), .phase(r_phase)
  );

  typedef struct {
    int                     ch0;
    int                     ch1;
    int                     gap;
    int                     n_out;
    logic [3:0][15:0]       e0;
    logic [3:0][15:0]       e1;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane(input int c);
    return int'($signed(out_data[c*16 +: 16]));
  endfunction

  function automatic int rlane(input int c);
    return int'($signed(r_out[c*15 +: 15]));
  endfunction

  // Streams a constant pair; predicts strobe edges from the sample count and
  // expects out_valid exactly 4 edges after each strobe, spaced 8*gap apart.
  task automatic run_dc(input vec_t v, input bit do_rst, input string tag);
    int cyc = 0, nsamp = 0, nout = 0, last = 0, budget, k;
    int expq [$];
    bit exp_now;
    if (do_rst) begin
      rstn = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
    end
    in_data = {16'(v.ch1), 16'(v.ch0)};
    budget = (v.n_out + 2) * 8 * v.gap + 20;
    while (nout < v.n_out && cyc < budget) begin
      in_valid = ((cyc % v.gap) == 0);
      if (in_valid) begin
        if (nsamp % 8 == 7) expq.push_back(cyc + 1 + 4);
        nsamp++;
      end
      @(posedge clk); cyc++; #1;
      exp_now = (expq.size() > 0) && (expq[0] == cyc);
      if (exp_now) void'(expq.pop_front());
      if (out_valid || exp_now) begin
        check({tag, " out_valid"}, out_valid, exp_now);
        if (out_valid) begin
          k = (nout < 3) ? nout : 3;
          check($sformatf("%s ch0 out%0d", tag, nout), lane(0), $signed(v.e0[k]));
          check($sformatf("%s ch1 out%0d", tag, nout), lane(1), $signed(v.e1[k]));
          if (nout > 0) check({tag, " spacing"}, cyc - last, 8 * v.gap);
          last = cyc;
          nout++;
        end
      end
    end
    in_valid = 1'b0;
    if (nout < v.n_out) check({tag, " timeout outputs"}, nout, v.n_out);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int nout;
    int rexp0, rexp1;

    in_data = '0; in_valid = 1'b0; r_in = '0; r_valid = 1'b0;

    vecs[0] = '{ch0: 100, ch1: 100, gap: 1, n_out: 6,
                e0: {16'sd100, 16'sd99, 16'sd68, 16'sd6},
                e1: {16'sd100, 16'sd99, 16'sd68, 16'sd6}};
    vecs[1] = '{ch0: -100, ch1: 2000, gap: 1, n_out: 6,
                e0: {-16'sd100, -16'sd100, -16'sd69, -16'sd7},
                e1: {16'sd2000, 16'sd1996, 16'sd1367, 16'sd136}};
    vecs[2] = '{ch0: 100, ch1: 100, gap: 3, n_out: 6,
                e0: {16'sd100, 16'sd99, 16'sd68, 16'sd6},
                e1: {16'sd100, 16'sd99, 16'sd68, 16'sd6}};
    vecs[3] = '{ch0: -100, ch1: 2000, gap: 3, n_out: 6,
                e0: {-16'sd100, -16'sd100, -16'sd69, -16'sd7},
                e1: {16'sd2000, 16'sd1996, 16'sd1367, 16'sd136}};
    vecs[4] = '{ch0: 32767, ch1: -32768, gap: 1, n_out: 1250,
                e0: {16'sd32767, 16'sd32703, 16'sd22399, 16'sd2239},
                e1: {16'h8000, -16'sd32704, -16'sd22400, -16'sd2240}};

    // Reset state
    @(posedge clk); #1;
    check("reset phase", phase, 0);
    check("reset out_valid", out_valid, 0);
    check("reset ch0", lane(0), 0);
    check("reset ch1", lane(1), 0);
    check("reset rnd phase", r_phase, 0);
    rstn = 1'b1;

    // Phase counting, hold on gaps, wrap
    in_valid = 1'b1; repeat (3) @(posedge clk); #1;
    check("phase after 3", phase, 3);
    in_valid = 1'b0; repeat (2) @(posedge clk); #1;
    check("phase hold", phase, 3);
    in_valid = 1'b1; repeat (5) @(posedge clk); #1;
    check("phase wrap", phase, 0);
    repeat (1) @(posedge clk); #1;
    check("phase after wrap", phase, 1);
    in_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_dc(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset one cycle after the second strobe
    rstn = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    in_data = {16'd100, 16'd100}; in_valid = 1'b1;
    repeat (17) @(posedge clk); #1;
    check("pre-rst ch0", lane(0), 6);
    check("pre-rst phase", phase, 1);
    rstn = 1'b0; #1;
    check("mid-rst phase", phase, 0);
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst ch0", lane(0), 0);
    check("mid-rst ch1", lane(1), 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; seen |= out_valid; end
    rstn = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; seen |= out_valid; end
    check("no stale out_valid", seen, 0);
    check("post-rst phase", phase, 0);
    run_dc(vecs[0], 1'b0, "post-rst");

    // Rounding instance (OUT_W=15): DC +3 / -3
`ifdef CIC_OUT_ROUND_EN
    rexp0 = 2; rexp1 = -1;
`else
    rexp0 = 1; rexp1 = -2;
`endif
    rstn = 1'b0; @(posedge clk); #1; rstn = 1'b1;
    r_in = {16'hFFFD, 16'd3}; r_valid = 1'b1;
    nout = 0;
    for (int i = 0; i < 200 && nout < 6; i++) begin
      @(posedge clk); #1;
      if (r_ovalid) begin
        if (nout >= 3) begin
          check($sformatf("rnd ch0 out%0d", nout), rlane(0), rexp0);
          check($sformatf("rnd ch1 out%0d", nout), rlane(1), rexp1);
        end
        nout++;
      end
    end
    r_valid = 1'b0;
    check("rnd output count", nout, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
